// File: rtl/flow_pm_pkg.sv
// Shared types, fixed-point constants and byte-order helpers for the
// per-flow packet manager.
package flow_pm_pkg;
    localparam int FRAC_BITS = 8;
    localparam int SIZE_W    = 11;
    localparam int ACC_W     = SIZE_W + FRAC_BITS + 1;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_FIFO = 2'd1,
        ST_ACK       = 2'd2
    } pm_state_e;

    // Reset constants are written MSB-first; the wire carries the low byte first.
    function automatic logic [47:0] bswap48(input logic [47:0] v);
        logic [47:0] r;
        for (int i = 0; i < 6; i++) r[8*i +: 8] = v[8*(5-i) +: 8];
        return r;
    endfunction

    function automatic logic [15:0] bswap16(input logic [15:0] v);
        return {v[7:0], v[15:8]};
    endfunction
endpackage

// File: rtl/pm_token_bucket.sv
// Fractional token accumulator that turns a Q8.8 byte rate into owed frames,
// with a saturating owed-frame counter and a saturating drop counter.
module pm_token_bucket
    import flow_pm_pkg::*;
#(
    parameter  int RATE_WIDTH  = 16,
    parameter  int MAX_PENDING = 8,
    localparam int PEND_W      = $clog2(MAX_PENDING + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  run,
    input  logic                  clr,
    input  logic                  dec,
    input  logic [RATE_WIDTH-1:0] rate,
    input  logic [SIZE_W-1:0]     size,
    output logic [PEND_W-1:0]     pending,
    output logic [15:0]           drop_count
);
    localparam int SUM_W = ACC_W + 1;

    logic [ACC_W-1:0]  r_acc;
    logic [PEND_W-1:0] r_pending;
    logic [15:0]       r_drops;

    logic [SIZE_W-1:0] w_size_eff;
    logic [SUM_W-1:0]  w_thr;
    logic [SUM_W-1:0]  w_sum;
    logic [SUM_W-1:0]  w_rem;
    logic [ACC_W-1:0]  w_acc_nxt;
    logic              w_gen;
    logic              w_dec;
    logic              w_full;
    logic              w_drop;

    always_comb begin
        w_size_eff = (size == '0) ? SIZE_W'(1) : size;
        w_thr      = SUM_W'(w_size_eff) << FRAC_BITS;
        w_sum      = SUM_W'(r_acc) + SUM_W'(rate);
        w_rem      = w_sum - w_thr;
        w_gen      = run && !clr && (w_sum >= w_thr);
        w_dec      = dec && (r_pending != '0);
        w_full     = (r_pending == PEND_W'(MAX_PENDING));
        w_drop     = w_gen && w_full && !w_dec;

        // Only one frame per cycle: a remainder still above threshold is thrown away.
        w_acc_nxt = r_acc;
        if (clr)
            w_acc_nxt = '0;
        else if (w_gen)
            w_acc_nxt = (w_rem >= w_thr) ? '0 : w_rem[ACC_W-1:0];
        else if (run)
            w_acc_nxt = w_sum[ACC_W-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc     <= '0;
            r_pending <= '0;
            r_drops   <= '0;
        end else begin
            r_acc <= w_acc_nxt;
            if (w_gen && !w_drop && !w_dec)
                r_pending <= r_pending + PEND_W'(1);
            else if (!w_gen && w_dec)
                r_pending <= r_pending - PEND_W'(1);
            if (w_drop && (r_drops != 16'hFFFF))
                r_drops <= r_drops + 16'd1;
        end
    end

    assign pending    = r_pending;
    assign drop_count = r_drops;
endmodule

// File: rtl/flow_packet_manager.sv
// Per-flow frame pacing and FIFO handshake controller; header configuration is
// shadowed and committed only between frames.
module flow_packet_manager
    import flow_pm_pkg::*;
#(
    parameter  int                    ID          = 0,
    parameter  int                    N_FLOWS     = 4,
    parameter  logic [SIZE_W-1:0]     DEF_SIZE    = 11'd64,
    parameter  int                    RATE_WIDTH  = 16,
    parameter  logic [RATE_WIDTH-1:0] DEF_RATE    = RATE_WIDTH'('h0100),
    parameter  int                    MAX_PENDING = 8,
    parameter  logic [7:0]            PAYLOAD     = 8'h1A,
    parameter  logic [47:0]           MAC_D       = 48'hBC9A78563412,
    parameter  logic [47:0]           MAC_S       = 48'h111111111111,
    parameter  logic [15:0]           ETHERTYPE   = 16'h0800,
    localparam int                    FLOW_WIDTH  = (N_FLOWS > 1) ? $clog2(N_FLOWS) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  run,
    output logic                  arb_request,
    input  logic                  arb_grant,
    output logic                  arb_ack,
    input  logic                  fifo_wr_ready,
    output logic                  fifo_wr_enable,
    input  logic                  cfg_en,
    input  logic [FLOW_WIDTH-1:0] cfg_id,
    input  logic [SIZE_W-1:0]     cfg_size,
    input  logic [RATE_WIDTH-1:0] cfg_rate,
    input  logic [31:0]           cfg_pkt_limit,
    input  logic [47:0]           cfg_d_mac,
    input  logic [47:0]           cfg_s_mac,
    input  logic [15:0]           cfg_ethertype,
    input  logic [7:0]            cfg_payload,
    output logic [SIZE_W-1:0]     size,
    output logic [47:0]           d_mac,
    output logic [47:0]           s_mac,
    output logic [15:0]           ethertype,
    output logic [7:0]            payload,
    output logic [31:0]           pkt_count,
    output logic [15:0]           drop_count,
    output logic                  done
);
    localparam int PEND_W = $clog2(MAX_PENDING + 1);

    pm_state_e             r_state;
    pm_state_e             w_state_nxt;
    logic                  r_wr_en;
    logic                  r_ack;
    logic                  w_wr_nxt;
    logic                  w_ack_nxt;
    logic [31:0]           r_pkt_count;
    logic                  r_done;

    logic [SIZE_W-1:0]     r_size,   r_sh_size;
    logic [RATE_WIDTH-1:0] r_rate,   r_sh_rate;
    logic [31:0]           r_limit,  r_sh_limit;
    logic [47:0]           r_d_mac,  r_sh_d_mac;
    logic [47:0]           r_s_mac,  r_sh_s_mac;
    logic [15:0]           r_eth,    r_sh_eth;
    logic [7:0]            r_pay,    r_sh_pay;
    logic                  r_dirty;

    logic                  w_hit;
    logic                  w_commit;
    logic                  w_req;
    logic                  w_dec;
    logic [PEND_W-1:0]     w_pending;

    assign w_hit    = cfg_en && (cfg_id == FLOW_WIDTH'(ID));
    assign w_req    = (r_state == ST_IDLE) && (w_pending != '0) && !r_done;
    assign w_dec    = (r_state == ST_ACK);
    // Commit only between frames; a write landing in that same cycle is taken directly.
    assign w_commit = (r_state == ST_IDLE) && !arb_grant && (r_dirty || w_hit);

    pm_token_bucket #(
        .RATE_WIDTH (RATE_WIDTH),
        .MAX_PENDING(MAX_PENDING)
    ) u_bucket (
        .clk       (clk),
        .rst       (rst),
        .run       (run && !r_done),
        .clr       (w_commit),
        .dec       (w_dec),
        .rate      (r_rate),
        .size      (r_size),
        .pending   (w_pending),
        .drop_count(drop_count)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_wr_nxt    = 1'b0;
        w_ack_nxt   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (arb_grant && w_req) w_state_nxt = ST_WAIT_FIFO;
            end
            ST_WAIT_FIFO: begin
                if (!arb_grant) begin
                    w_state_nxt = ST_IDLE;
                end else if (fifo_wr_ready) begin
                    w_state_nxt = ST_ACK;
                    w_wr_nxt    = 1'b1;
                end
            end
            ST_ACK: begin
                w_state_nxt = ST_IDLE;
                w_ack_nxt   = 1'b1;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_wr_en <= 1'b0;
            r_ack   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_wr_en <= w_wr_nxt;
            r_ack   <= w_ack_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pkt_count <= '0;
            r_done      <= 1'b0;
        end else if (w_commit) begin
            r_pkt_count <= '0;
            r_done      <= 1'b0;
        end else if (w_dec) begin
            r_pkt_count <= r_pkt_count + 32'd1;
            if ((r_limit != '0) && (r_pkt_count + 32'd1 == r_limit))
                r_done <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sh_size  <= DEF_SIZE;
            r_sh_rate  <= DEF_RATE;
            r_sh_limit <= '0;
            r_sh_d_mac <= bswap48(MAC_D);
            r_sh_s_mac <= bswap48(MAC_S);
            r_sh_eth   <= bswap16(ETHERTYPE);
            r_sh_pay   <= PAYLOAD;
            r_dirty    <= 1'b0;
        end else begin
            if (w_hit) begin
                r_sh_size  <= cfg_size;
                r_sh_rate  <= cfg_rate;
                r_sh_limit <= cfg_pkt_limit;
                r_sh_d_mac <= cfg_d_mac;
                r_sh_s_mac <= cfg_s_mac;
                r_sh_eth   <= cfg_ethertype;
                r_sh_pay   <= cfg_payload;
            end
            if (w_commit)
                r_dirty <= 1'b0;
            else if (w_hit)
                r_dirty <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_size  <= DEF_SIZE;
            r_rate  <= DEF_RATE;
            r_limit <= '0;
            r_d_mac <= bswap48(MAC_D);
            r_s_mac <= bswap48(MAC_S);
            r_eth   <= bswap16(ETHERTYPE);
            r_pay   <= PAYLOAD;
        end else if (w_commit) begin
            r_size  <= w_hit ? cfg_size      : r_sh_size;
            r_rate  <= w_hit ? cfg_rate      : r_sh_rate;
            r_limit <= w_hit ? cfg_pkt_limit : r_sh_limit;
            r_d_mac <= w_hit ? cfg_d_mac     : r_sh_d_mac;
            r_s_mac <= w_hit ? cfg_s_mac     : r_sh_s_mac;
            r_eth   <= w_hit ? cfg_ethertype : r_sh_eth;
            r_pay   <= w_hit ? cfg_payload   : r_sh_pay;
        end
    end

    assign arb_request    = w_req;
    assign arb_ack        = r_ack;
    assign fifo_wr_enable = r_wr_en;
    assign pkt_count      = r_pkt_count;
    assign done           = r_done;
    assign size           = r_size;
    assign d_mac          = r_d_mac;
    assign s_mac          = r_s_mac;
    assign ethertype      = r_eth;
    assign payload        = r_pay;
endmodule

// File: doc/flow_packet_manager.md
Name: flow_packet_manager

Overview:
Per-flow packet-generation controller, generalising the fixed-rate single-bit-request packet manager.
- Paces frame emission with a runtime-programmable fractional token accumulator.
- Queues up to MAX_PENDING owed frames instead of a single pending bit.
- Supports continuous or N-packet burst mode, and commits header configuration only at frame boundaries.
- One instance per flow; it sits between the flow arbiter and the shared frame FIFO/frame builder.

Parameters:
ID, 0, flow index matched against cfg_id
N_FLOWS, 4, number of flows; FLOW_WIDTH = N_FLOWS>1 ? clog2(N_FLOWS) : 1
DEF_SIZE, 64, reset frame size in bytes (11-bit)
RATE_WIDTH, 16, width of rate increment; 8 fractional bits (bytes/cycle in Q8.8)
DEF_RATE, 16'h0100, reset rate increment (1.0 byte/cycle)
MAX_PENDING, 8, owed-frame counter saturation value (>=1)
PAYLOAD, 8'h1A, reset payload byte
MAC_D, 48'hBC9A78563412, reset destination MAC (byte-swapped on reset load)
MAC_S, 48'h111111111111, reset source MAC (byte-swapped)
ETHERTYPE, 16'h0800, reset ethertype (byte-swapped)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
run  in  1  level; 1 = accumulate tokens and issue requests
arb_request  out  1  flow wants the FIFO
arb_grant  in  1  arbiter grant to this flow
arb_ack  out  1  one-cycle pulse: frame committed, grant may be released
fifo_wr_ready  in  1  FIFO can accept a frame command
fifo_wr_enable  out  1  one-cycle frame-command write strobe
cfg_en  in  1  configuration write strobe
cfg_id  in  FLOW_WIDTH  target flow
cfg_size  in  11  frame size in bytes
cfg_rate  in  RATE_WIDTH  Q8.8 byte increment per cycle
cfg_pkt_limit  in  32  frames per burst; 0 = continuous
cfg_d_mac, cfg_s_mac  in  48 each  header MACs (already wire order)
cfg_ethertype  in  16  ethertype (wire order)
cfg_payload  in  8  payload byte
size  out  11  active frame size
d_mac, s_mac  out  48 each  active MACs
ethertype  out  16  active ethertype
payload  out  8  active payload
pkt_count  out  32  frames written since reset/config
drop_count  out  16  frames lost to pending saturation, saturating
done  out  1  burst limit reached

Behaviour:
- Reset (async, rst=1): state IDLE; accumulator 0; pending 0; pkt_count 0; drop_count 0; done 0; arb_request 0; arb_ack 0; fifo_wr_enable 0; size=DEF_SIZE; rate=DEF_RATE; limit=0; header outputs = byte-swapped parameters; shadow registers equal active registers.
- Accumulator: width 11+8+1 bits. Each cycle with run=1 and done=0: acc += rate.
  - If acc >= size<<8: acc -= size<<8, and an owed frame is generated.
  - At most one owed frame per cycle.
  - If pending==MAX_PENDING, the owed frame is dropped: drop_count++, saturating at 16'hFFFF.
  - run=0 freezes acc; pending is kept.
- pending: owed-frame generation and frame commit in the same cycle leave pending unchanged.
- FSM:
  - IDLE: arb_request = (pending!=0) && !done. On arb_grant -> WAIT_FIFO.
  - WAIT_FIFO: arb_request=0. On fifo_wr_ready -> register fifo_wr_enable=1 for exactly one cycle -> ACK. If arb_grant drops first -> IDLE with no write.
  - ACK: arb_ack=1 for one cycle; pending--; pkt_count++; if limit!=0 and pkt_count+1==limit, set done -> IDLE.
- Latency: grant -> fifo_wr_enable is 1 cycle after fifo_wr_ready is seen in WAIT_FIFO; arb_ack follows one cycle after that.
- Configuration:
  - cfg_en && cfg_id==ID loads all cfg_* into shadow registers.
  - Shadows commit to active outputs/size/rate/limit only in IDLE with no grant, so headers never change mid-frame.
  - Commit clears acc, pkt_count and done; pending is kept.
  - cfg_en to a different ID is ignored.
  - A cfg_en in the commit cycle wins: the new values are taken.
- Boundaries:
  - size=0 is treated as 1.
  - rate=0 never generates frames.
  - rate >= size<<8 yields one frame per cycle max; the excess is discarded, not carried.
  - rst mid-frame aborts with no further strobes.

Decomposition:
- Package flow_pm_pkg: FSM state encoding (IDLE, WAIT_FIFO, ACK), Q8.8 fraction constant FRAC_BITS=8, and the byte-swap functions for 48-bit and 16-bit fields.
- Sub-module pm_token_bucket: accumulator, saturating pending counter and drop counter, with inputs run, rate, size, dec.

Test Plan:
- Reset with defaults: d_mac=48'h123456789ABC, ethertype=16'h0008, size=64; all strobes 0; pkt_count=0.
- rate=16'h0100, size=64, run=1, grant returned next cycle, fifo ready: one fifo_wr_enable every 64 cycles ±1; pkt_count increments each frame; arb_ack one cycle after each write.
- Grant withheld, rate=16'h4000, size=64 (one frame per cycle): pending saturates at 8; drop_count counts every further cycle; releasing grant drains 8 frames.
- cfg_pkt_limit=3: exactly 3 writes, then done=1 and arb_request stays 0; reconfiguring clears done.
- cfg_en with new d_mac while in WAIT_FIFO: d_mac unchanged until after arb_ack, then updates; cfg_id≠ID leaves all outputs unchanged.
- Assert rst in WAIT_FIFO with fifo_wr_ready=1: no fifo_wr_enable or arb_ack; all outputs at reset values the same cycle.
